led_pattern_scheduler: RTL and testbench

//  Sequences the 8 board LEDs through four selectable patterns at a programmable tick rate.

---
 rtl/led_sched_pkg.sv | 25 ++
 rtl/btn_conditioner.sv | 51 +++++
 rtl/led_pattern_scheduler.sv | 116 +++++++++++
 tb/tb_led_pattern_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_sched_pkg.sv
// Shared mode encoding and per-mode initial LED patterns for the LED pattern scheduler.
package led_sched_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_COUNT  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_ALT    = 2'd3
  } mode_e;

  localparam logic [7:0] INIT_BLINK  = 8'h00;
  localparam logic [7:0] INIT_COUNT  = 8'h00;
  localparam logic [7:0] INIT_BOUNCE = 8'h01;
  localparam logic [7:0] INIT_ALT    = 8'h55;

  function automatic logic [7:0] init_pattern(input mode_e m);
    case (m)
      MODE_COUNT:  return INIT_COUNT;
      MODE_BOUNCE: return INIT_BOUNCE;
      MODE_ALT:    return INIT_ALT;
      default:     return INIT_BLINK;
    endcase
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Async button conditioner: 2-flop synchroniser, stability debounce, and a
// single-cycle press pulse on each debounced rising edge.
module btn_conditioner #(
  parameter int unsigned DB_CYCLES = 120_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_async,
  output logic press
);

  localparam int unsigned DW = $clog2(DB_CYCLES + 1);

  logic [1:0]    sync_q, sync_d;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;

  // db_cnt counts consecutive cycles the synced input disagrees with the
  // debounced state; any agreement restarts the count.
  always_comb begin
    sync_d   = {sync_q[0], btn_async};
    stable_d = stable_q;
    db_cnt_d = '0;
    if (sync_q[1] != stable_q) begin
      if (db_cnt_q == DW'(DB_CYCLES - 1)) begin
        stable_d = sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    press_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/led_pattern_scheduler.sv
// Board LED controller: steps one of four patterns on a programmable tick,
// with button-driven mode advance and pause/run.
module led_pattern_scheduler
  import led_sched_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 12_000_000,
  parameter int unsigned TICK_HZ   = 1,
  parameter int unsigned DB_CYCLES = 120_000
) (
  input  logic       BOARD_CLK,
  input  logic       BOARD_RST,
  input  logic       BOARD_SW1,
  input  logic       BOARD_SW2,
  input  logic [1:0] speed_sel,
  output logic [7:0] BOARD_LED,
  output logic       tick,
  output logic [1:0] mode,
  output logic       paused
);

  localparam int unsigned PERIOD = CLK_HZ / TICK_HZ;
  localparam int unsigned CW     = $clog2(PERIOD);

  logic          press1, press2;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   limit, cnt_ext;
  logic          tick_w;
  mode_e         mode_q, mode_d, pending_q, pending_d, next_pending;
  logic [7:0]    led_q, led_d;
  logic          dir_q, dir_d;
  logic          paused_q, paused_d;
  logic          apply_new;

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_mode (
    .clk       (BOARD_CLK),
    .rst       (BOARD_RST),
    .btn_async (BOARD_SW1),
    .press     (press1)
  );

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_pause (
    .clk       (BOARD_CLK),
    .rst       (BOARD_RST),
    .btn_async (BOARD_SW2),
    .press     (press2)
  );

  // >= rather than == so a speed change that lowers the limit below the
  // current count still produces a tick instead of a long wraparound.
  assign limit   = PERIOD >> speed_sel;
  assign cnt_ext = 32'(cnt_q);
  assign tick_w  = ~paused_q & (cnt_ext >= limit - 32'd1);

  always_comb begin
    next_pending = press1 ? mode_e'(pending_q + 2'd1) : pending_q;
    cnt_d        = (paused_q | tick_w) ? '0 : cnt_q + 1'b1;
    pending_d    = next_pending;
    paused_d     = paused_q ^ press2;
    mode_d       = mode_q;
    led_d        = led_q;
    dir_d        = dir_q;
    // Mode decision uses the pre-toggle paused value.
    apply_new    = (next_pending != mode_q) & (paused_q | tick_w);
    if (apply_new) begin
      mode_d = next_pending;
      led_d  = init_pattern(next_pending);
      dir_d  = 1'b0;
    end else if (tick_w) begin
      case (mode_q)
        MODE_COUNT: led_d = led_q + 8'd1;
        MODE_BOUNCE: begin
          if (!dir_q) begin
            if (led_q == 8'h80) begin
              led_d = 8'h40;
              dir_d = 1'b1;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q == 8'h01) begin
              led_d = 8'h02;
              dir_d = 1'b0;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
        default: led_d = ~led_q;
      endcase
    end
  end

  always_ff @(posedge BOARD_CLK) begin
    if (BOARD_RST) begin
      cnt_q     <= '0;
      mode_q    <= MODE_BLINK;
      pending_q <= MODE_BLINK;
      led_q     <= INIT_BLINK;
      dir_q     <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      led_q     <= led_d;
      dir_q     <= dir_d;
      paused_q  <= paused_d;
    end
  end

  assign BOARD_LED = led_q;
  assign tick      = tick_w;
  assign mode      = mode_q;
  assign paused    = paused_q;

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Bench for led_pattern_scheduler: per-cycle comparison against a behavioural
// model plus literal checks on tick cadence, pattern sequences and pause timing.
module tb_led_pattern_scheduler;

  localparam int PERIOD = 16;
  localparam int DB     = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw1 = 1'b0;
  logic       sw2 = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [7:0] led;
  logic       tick;
  logic [1:0] mode;
  logic       paused;

  always #5 clk = ~clk;

  led_pattern_scheduler #(.CLK_HZ(16), .TICK_HZ(1), .DB_CYCLES(DB)) dut (
    .BOARD_CLK (clk),
    .BOARD_RST (rst),
    .BOARD_SW1 (sw1),
    .BOARD_SW2 (sw2),
    .speed_sel (speed),
    .BOARD_LED (led),
    .tick      (tick),
    .mode      (mode),
    .paused    (paused)
  );

  // Behavioural model: pattern is a function of (mode, steps since mode entry).
  int m_mode, m_step, m_pending, m_cnt;
  bit m_paused;
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_stable [2];
  bit m_press [2];
  bit m_hist [2][DB];

  function automatic logic [7:0] pat(input int md, input int st);
    int i;
    case (md)
      0: return (st % 2) ? 8'hFF : 8'h00;
      1: return 8'(st % 256);
      2: begin
        i = st % 14;
        return (i < 8) ? 8'(1 << i) : 8'(1 << (14 - i));
      end
      default: return (st % 2) ? 8'hAA : 8'h55;
    endcase
  endfunction

  function automatic bit model_tick();
    return !m_paused && (m_cnt >= (PERIOD >> speed) - 1);
  endfunction

  always @(posedge clk) begin
    bit tk, all_diff, new_st;
    int np;
    bit raw [2];
    if (rst) begin
      m_mode = 0; m_step = 0; m_pending = 0; m_cnt = 0; m_paused = 0;
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_stable[b] = 0; m_press[b] = 0;
        for (int i = 0; i < DB; i++) m_hist[b][i] = 0;
      end
    end else begin
      tk = model_tick();
      np = m_press[0] ? (m_pending + 1) % 4 : m_pending;
      if (np != m_mode && (m_paused || tk)) begin
        m_mode = np;
        m_step = 0;
      end else if (tk) begin
        m_step++;
      end
      m_cnt = (m_paused || tk) ? 0 : m_cnt + 1;
      if (m_press[1]) m_paused = !m_paused;
      m_pending = np;
      raw[0] = sw1;
      raw[1] = sw2;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DB - 1; i++) m_hist[b][i] = m_hist[b][i+1];
        m_hist[b][DB-1] = m_s2[b];
        all_diff = 1;
        for (int i = 0; i < DB; i++) if (m_hist[b][i] == m_stable[b]) all_diff = 0;
        new_st = all_diff ? !m_stable[b] : m_stable[b];
        m_press[b] = new_st && !m_stable[b];
        m_stable[b] = new_st;
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
    end
  end

  int tests = 0;
  int fails = 0;
  bit model_on = 0;
  logic [7:0] s_led;
  logic [1:0] s_mode;
  logic       s_tick, s_paused;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    s_led = led; s_mode = mode; s_tick = tick; s_paused = paused;
    if (model_on) begin
      chk("model_tick",   32'(s_tick),   32'(model_tick()));
      chk("model_led",    32'(s_led),    32'(pat(m_mode, m_step)));
      chk("model_mode",   32'(s_mode),   32'(m_mode));
      chk("model_paused", 32'(s_paused), 32'(m_paused));
    end
    @(posedge clk);
    #2;
  endtask

  task automatic wait_tick(input string name);
    bit got;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (s_tick) got = 1;
    end
    chk(name, 32'(got), 32'd1);
  endtask

  task automatic hold_sw1(input int len);
    sw1 = 1;
    repeat (len) step();
    sw1 = 0;
  endtask

  task automatic hold_sw2(input int len);
    sw2 = 1;
    repeat (len) step();
    sw2 = 0;
  endtask

  logic [7:0] bounce_exp [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  initial begin
    int n, cnt_ticks, hl0, hl1;
    bit got;
    logic [7:0] led0;
    logic [1:0] mode0;

    // Reset and basic BLINK cadence
    step();
    model_on = 1;
    step();
    step();
    rst = 0;
    for (int k = 1; k <= 49; k++) begin
      step();
      if (k == 1) begin
        chk("rst_led", 32'(s_led), 32'h00);
        chk("rst_mode", 32'(s_mode), 32'd0);
        chk("rst_paused", 32'(s_paused), 32'd0);
      end
      chk("t1_tick_cadence", 32'(s_tick), 32'((k % 16) == 0));
      if (k == 17) chk("t1_led_ff", 32'(s_led), 32'hFF);
      if (k == 33) chk("t1_led_00", 32'(s_led), 32'h00);
      if (k == 49) chk("t1_led_ff2", 32'(s_led), 32'hFF);
    end

    // Mode advance applied only at the next tick
    step(); step();
    hold_sw1(10);
    chk("t2_mode_before_tick", 32'(s_mode), 32'd0);
    wait_tick("t2_tick_a");
    step();
    chk("t2_mode_count", 32'(s_mode), 32'd1);
    chk("t2_led_init", 32'(s_led), 32'h00);
    wait_tick("t2_tick_b");
    step();
    chk("t2_led_01", 32'(s_led), 32'h01);
    wait_tick("t2_tick_c");
    step();
    chk("t2_led_02", 32'(s_led), 32'h02);

    // BOUNCE walk with reversal at both ends
    hold_sw1(10);
    wait_tick("t3_tick_entry");
    step();
    chk("t3_mode_bounce", 32'(s_mode), 32'd2);
    chk("t3_led_init", 32'(s_led), 32'h01);
    for (int k = 0; k < 15; k++) begin
      wait_tick("t3_tick");
      step();
      chk("t3_bounce_seq", 32'(s_led), 32'(bounce_exp[k]));
    end

    // Pause freezes pattern; mode change while paused; resume timing
    hold_sw2(8);
    step();
    chk("t4_paused", 32'(s_paused), 32'd1);
    led0 = s_led;
    cnt_ticks = 0;
    repeat (100) begin
      step();
      if (s_tick) cnt_ticks++;
    end
    chk("t4_no_ticks", 32'(cnt_ticks), 32'd0);
    chk("t4_led_frozen", 32'(s_led), 32'(led0));
    hold_sw1(8);
    step(); step();
    chk("t4_mode_alt", 32'(s_mode), 32'd3);
    chk("t4_led_alt_init", 32'(s_led), 32'h55);
    sw2 = 1;
    n = 0;
    got = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      if (i == 8) sw2 = 0;
      step();
      if (!s_paused) begin
        n++;
        if (s_tick) got = 1;
      end
    end
    sw2 = 0;
    chk("t4_resume_tick_seen", 32'(got), 32'd1);
    chk("t4_resume_gap", 32'(n), 32'd16);

    // Speed select
    speed = 2'd3;
    cnt_ticks = 0;
    repeat (20) begin
      step();
      if (s_tick) cnt_ticks++;
    end
    chk("t5_fast_ticks", 32'(cnt_ticks), 32'd10);
    speed = 2'd0;
    wait_tick("t5_tick_sync");
    repeat (10) step();
    speed = 2'd2;
    step();
    chk("t5_lowered_limit_tick", 32'(s_tick), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t5_limit4_cadence", 32'(s_tick), 32'(k == 4));
    end

    // Short glitch ignored; reset mid-operation
    speed = 2'd0;
    mode0 = s_mode;
    sw1 = 1;
    step(); step();
    sw1 = 0;
    repeat (40) step();
    chk("t6_glitch_ignored", 32'(s_mode), 32'(mode0));
    wait_tick("t6_tick_sync");
    repeat (9) step();
    rst = 1;
    step();
    rst = 0;
    step();
    chk("t6_rst_led", 32'(s_led), 32'h00);
    chk("t6_rst_mode", 32'(s_mode), 32'd0);
    chk("t6_rst_paused", 32'(s_paused), 32'd0);
    n = 1;
    got = s_tick;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      n++;
      if (s_tick) got = 1;
    end
    chk("t6_first_tick_after_rst", 32'(n), 32'd16);

    // Randomised soak against the model
    hl0 = 0;
    hl1 = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hl0 == 0 && $urandom_range(0, 19) == 0) hl0 = $urandom_range(1, 12);
      if (hl1 == 0 && $urandom_range(0, 29) == 0) hl1 = $urandom_range(1, 12);
      sw1 = (hl0 > 0);
      sw2 = (hl1 > 0);
      if (hl0 > 0) hl0--;
      if (hl1 > 0) hl1--;
      if ($urandom_range(0, 199) == 0) speed = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 0;
    sw1 = 0;
    sw2 = 0;
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
